// File: rtl/button_event.sv
// button_event: turns a debounced switch level into single-cycle user-event
// strobes (press, release, long-press, auto-repeat, double-click) plus a
// held level.
//
// Ports:
//   clk_i      clock
//   rst_i      synchronous reset, active-high
//   clean_i    debounced switch level, 1 = pressed, synchronous to clk_i
//   press_o    one-cycle pulse on each press
//   release_o  one-cycle pulse on each release
//   long_o     one-cycle pulse when a hold reaches long_cyc cycles
//   repeat_o   one-cycle pulse every rpt_cyc cycles while held after long_o
//   dbl_o      one-cycle pulse on the second press of a double-click
//   held_o     level, 1 while the button is considered held
module button_event #(
  parameter int unsigned cnt_bits = 26,
  parameter int unsigned long_cyc = 25000000,
  parameter int unsigned rpt_cyc  = 5000000,
  parameter int unsigned dbl_cyc  = 12500000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clean_i,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o,
  output logic dbl_o,
  output logic held_o
);

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    HOLD2,
    REPEAT,
    GAP
  } state_t;

  localparam logic [cnt_bits-1:0] LONG_M1 = cnt_bits'(long_cyc - 1);
  localparam logic [cnt_bits-1:0] RPT_M1  = cnt_bits'(rpt_cyc - 1);
  localparam logic [cnt_bits-1:0] DBL_M1  = cnt_bits'(dbl_cyc - 1);

  state_t              state_q, state_d;
  logic [cnt_bits-1:0] cnt_q, cnt_d;
  logic                clean_q;
  logic                press_q, press_d;
  logic                release_q, release_d;
  logic                long_q, long_d;
  logic                repeat_q, repeat_d;
  logic                dbl_q, dbl_d;
  logic                held_q, held_d;
  logic                rise, fall;

  assign rise = clean_i & ~clean_q;
  assign fall = ~clean_i & clean_q;

  // Counter defaults to clear; it only advances when the state is kept,
  // so every transition clears it implicitly.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    dbl_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          press_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD, HOLD2: begin
        if (fall) begin
          release_d = 1'b1;
          // Only a first press arms the double-click window.
          state_d   = (state_q == HOLD) ? GAP : IDLE;
        end else if (cnt_q == LONG_M1) begin
          long_d  = 1'b1;
          state_d = REPEAT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REPEAT: begin
        if (fall) begin
          release_d = 1'b1;
          state_d   = IDLE;
        end else if (cnt_q == RPT_M1) begin
          repeat_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (rise) begin
          press_d = 1'b1;
          dbl_d   = 1'b1;
          state_d = HOLD2;
        end else if (cnt_q == DBL_M1) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    held_d = (state_d == HOLD) || (state_d == HOLD2) || (state_d == REPEAT);
  end

  always_ff @(posedge clk_i) begin
    // clean_q follows the input even in reset so a button held through
    // reset does not look like a fresh press.
    clean_q <= clean_i;
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      dbl_q     <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      dbl_q     <= dbl_d;
      held_q    <= held_d;
    end
  end

  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;
  assign repeat_o  = repeat_q;
  assign dbl_o     = dbl_q;
  assign held_o    = held_q;

endmodule
